// File: rtl/pci_pkg.sv
// Shared definitions for the PCI-style bus agent: command codes, FSM state
// encodings and the released (idle) levels of the active-low bus controls.
package pci_pkg;

    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;

    localparam logic       CTL_IDLE   = 1'b1;     // released active-low control
    localparam logic [3:0] CBE_ALL    = 4'b0000;  // all byte lanes enabled

    typedef enum logic [2:0] {I_IDLE, I_REQ, I_ADDR, I_DATA, I_TURN} istate_t;
    typedef enum logic [1:0] {T_IDLE, T_CLAIM, T_DATA, T_TURN} tstate_t;

    function automatic logic is_mem_cmd(input logic [3:0] c);
        return (c == CMD_MEM_RD) || (c == CMD_MEM_WR);
    endfunction

endpackage

// File: rtl/pci_target.sv
// Target half of the bus agent: claims memory read/write bursts on IDSEL and
// serves a small word memory. Define TARGET_WAIT_EN for one wait state per phase.
module pci_target
    import pci_pkg::*;
#(
    parameter int MEM_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ad_in,
    input  logic [3:0]  cbe_in,
    input  logic        frame_in,
    input  logic        irdy_in,
    input  logic        trdy_in,
    input  logic        idsel,
    output logic        trdy,
    output logic        devsel,
    output logic        ad_oe,
    output logic [31:0] ad_out
);

    localparam int IW = $clog2(MEM_DEPTH);

    tstate_t       state, state_nxt;
    logic [31:0]   mem [MEM_DEPTH];
    logic [IW-1:0] idx;
    logic          is_rd;
    logic          frame_d;
    logic          rdy;
    logic          xfer;

`ifdef TARGET_WAIT_EN
    logic wt;  // high during the inserted wait cycle of the current phase

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wt <= 1'b0;
        else     wt <= (state == T_CLAIM) || xfer;
    end
    assign rdy = !wt;
`else
    assign rdy = 1'b1;
`endif

    assign xfer = (state == T_DATA) && rdy && !irdy_in && !trdy_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= T_IDLE;
            idx     <= '0;
            is_rd   <= 1'b0;
            frame_d <= CTL_IDLE;
        end else begin
            state   <= state_nxt;
            frame_d <= frame_in;
            if (state == T_IDLE && state_nxt == T_CLAIM) begin
                idx   <= ad_in[IW+1:2];
                is_rd <= (cbe_in == CMD_MEM_RD);
            end else if (xfer) begin
                idx <= idx + IW'(1);
            end
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (xfer && !is_rd) begin
            for (int b = 0; b < 4; b++)
                if (!cbe_in[b]) mem[idx][8*b +: 8] <= ad_in[8*b +: 8];
        end
    end

    always_comb begin
        state_nxt = state;
        trdy      = CTL_IDLE;
        devsel    = CTL_IDLE;
        ad_oe     = 1'b0;
        ad_out    = mem[idx];
        case (state)
            T_IDLE: begin
                // only the falling edge of FRAME# marks an address phase
                if (!frame_in && frame_d && idsel && is_mem_cmd(cbe_in))
                    state_nxt = T_CLAIM;
            end
            T_CLAIM: begin
                devsel    = 1'b0;
                ad_oe     = is_rd;
                state_nxt = T_DATA;
            end
            T_DATA: begin
                devsel = 1'b0;
                ad_oe  = is_rd;
                trdy   = !rdy;
                if (xfer && frame_in) state_nxt = T_TURN;
            end
            T_TURN:  state_nxt = T_IDLE;
            default: state_nxt = T_IDLE;
        endcase
    end

endmodule

// File: rtl/pci_dev.sv
// PCI-style bus agent: initiator FSM plus a pci_target, both sharing AD/C_BE.
// Optional build macro TARGET_WAIT_EN adds one target wait state per data phase.
module pci_dev
    import pci_pkg::*;
#(
    parameter int NUM_DATA   = 3,
    parameter int MEM_DEPTH  = 8,
    parameter int ABORT_CLKS = 4
) (
    input  logic        CLK,
    input  logic        RST,
    inout  tri   [31:0] AD,
    inout  tri   [3:0]  C_BE,
    output logic        Frame,
    output logic        IRDY,
    output logic        TRDY,
    output logic        DEVSEL,
    input  logic        FRAME_IN,
    input  logic        IRDY_IN,
    input  logic        TRDY_IN,
    input  logic        DEVSEL_IN,
    input  logic        IDSEL,
    input  logic        GNT,
    output logic        REQ,
    input  logic [31:0] AD_TO_C,
    input  logic [3:0]  CBE_TO_C,
    input  logic        forced_en,
    output logic [31:0] RD_DATA,
    output logic        RD_VALID
);

    localparam int CW = $clog2(NUM_DATA + 1);
    localparam int AW = $clog2(ABORT_CLKS + 1);

    istate_t       state, state_nxt;
    logic          pending;
    logic [3:0]    cmd_q;
    logic [CW-1:0] cnt;
    logic [AW-1:0] abort_cnt;
    logic          devsel_seen;
    logic          is_rd, last, xfer, abort;
    logic          i_ad_oe, i_cbe_oe;
    logic [3:0]    i_cbe;
    logic          t_ad_oe;
    logic [31:0]   t_ad;

    assign is_rd = (cmd_q == CMD_MEM_RD);
    assign last  = (cnt == CW'(NUM_DATA - 1));
    assign xfer  = (state == I_DATA) && !IRDY_IN && !TRDY_IN;
    assign abort = (state == I_DATA) && !devsel_seen && DEVSEL_IN &&
                   (abort_cnt == AW'(ABORT_CLKS - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= I_IDLE;
            pending     <= 1'b0;
            cmd_q       <= '0;
            cnt         <= '0;
            abort_cnt   <= '0;
            devsel_seen <= 1'b0;
            RD_DATA     <= '0;
            RD_VALID    <= 1'b0;
        end else begin
            state    <= state_nxt;
            RD_VALID <= 1'b0;
            // a trigger seen while busy is remembered once and replayed from idle
            if (state == I_IDLE && state_nxt == I_REQ) pending <= 1'b0;
            else if (!forced_en)                        pending <= 1'b1;
            if (state == I_ADDR) begin
                cmd_q       <= CBE_TO_C;
                cnt         <= '0;
                abort_cnt   <= '0;
                devsel_seen <= 1'b0;
            end
            if (state == I_DATA) begin
                if (!DEVSEL_IN)        devsel_seen <= 1'b1;
                else if (!devsel_seen) abort_cnt   <= abort_cnt + AW'(1);
                if (xfer) begin
                    cnt <= cnt + CW'(1);
                    if (is_rd) begin
                        RD_DATA  <= AD;
                        RD_VALID <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        Frame     = CTL_IDLE;
        IRDY      = CTL_IDLE;
        REQ       = CTL_IDLE;
        i_ad_oe   = 1'b0;
        i_cbe_oe  = 1'b0;
        i_cbe     = CBE_TO_C;
        case (state)
            I_IDLE: if (pending || !forced_en) state_nxt = I_REQ;
            I_REQ: begin
                REQ = 1'b0;
                if (!GNT && FRAME_IN && IRDY_IN) state_nxt = I_ADDR;
            end
            I_ADDR: begin
                Frame     = 1'b0;
                i_ad_oe   = 1'b1;
                i_cbe_oe  = 1'b1;
                state_nxt = I_DATA;
            end
            I_DATA: begin
                IRDY     = 1'b0;
                Frame    = last;
                i_ad_oe  = !is_rd;
                i_cbe_oe = 1'b1;
                i_cbe    = CBE_ALL;
                if (abort || (xfer && last)) state_nxt = I_TURN;
            end
            I_TURN:  state_nxt = I_IDLE;
            default: state_nxt = I_IDLE;
        endcase
    end

    pci_target #(.MEM_DEPTH(MEM_DEPTH)) u_target (
        .clk      (CLK),
        .rst      (RST),
        .ad_in    (AD),
        .cbe_in   (C_BE),
        .frame_in (FRAME_IN),
        .irdy_in  (IRDY_IN),
        .trdy_in  (TRDY_IN),
        .idsel    (IDSEL),
        .trdy     (TRDY),
        .devsel   (DEVSEL),
        .ad_oe    (t_ad_oe),
        .ad_out   (t_ad)
    );

    logic        ad_oe;
    logic [31:0] ad_val;
    assign ad_oe  = i_ad_oe | t_ad_oe;
    assign ad_val = i_ad_oe ? AD_TO_C : t_ad;
    assign AD     = ad_oe    ? ad_val : 32'bz;
    assign C_BE   = i_cbe_oe ? i_cbe  : 4'bz;

endmodule

// File: tb/tb_pci_dev.sv
// Two agents on one wired-AND bus: u_a initiates, u_b is the target.
// Read words are scoreboarded against a behavioural memory model.
module tb_pci_dev;
    import pci_pkg::*;

    localparam int ND = 3, MD = 8, AC = 4;
`ifdef TARGET_WAIT_EN
    localparam int WS = 1;
`else
    localparam int WS = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    tri [31:0] ad;
    tri [3:0]  cbe;
    logic frame_a, irdy_a, trdy_a, devsel_a, req_a, rd_valid_a;
    logic frame_b, irdy_b, trdy_b, devsel_b, req_b, rd_valid_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic frame_in, irdy_in, trdy_in, devsel_in;
    logic gnt_a, idsel_b, forced_en_a;
    logic [31:0] ad_to_c;
    logic [3:0]  cbe_to_c;

    assign frame_in  = frame_a & frame_b;
    assign irdy_in   = irdy_a & irdy_b;
    assign trdy_in   = trdy_a & trdy_b;
    assign devsel_in = devsel_a & devsel_b;

    always #5 clk = ~clk;

    pci_dev #(.NUM_DATA(ND), .MEM_DEPTH(MD), .ABORT_CLKS(AC)) u_a (
        .CLK(clk), .RST(rst), .AD(ad), .C_BE(cbe),
        .Frame(frame_a), .IRDY(irdy_a), .TRDY(trdy_a), .DEVSEL(devsel_a),
        .FRAME_IN(frame_in), .IRDY_IN(irdy_in), .TRDY_IN(trdy_in), .DEVSEL_IN(devsel_in),
        .IDSEL(1'b0), .GNT(gnt_a), .REQ(req_a),
        .AD_TO_C(ad_to_c), .CBE_TO_C(cbe_to_c), .forced_en(forced_en_a),
        .RD_DATA(rd_data_a), .RD_VALID(rd_valid_a));

    pci_dev #(.NUM_DATA(ND), .MEM_DEPTH(MD), .ABORT_CLKS(AC)) u_b (
        .CLK(clk), .RST(rst), .AD(ad), .C_BE(cbe),
        .Frame(frame_b), .IRDY(irdy_b), .TRDY(trdy_b), .DEVSEL(devsel_b),
        .FRAME_IN(frame_in), .IRDY_IN(irdy_in), .TRDY_IN(trdy_in), .DEVSEL_IN(devsel_in),
        .IDSEL(idsel_b), .GNT(1'b1), .REQ(req_b),
        .AD_TO_C(32'h0), .CBE_TO_C(4'h0), .forced_en(1'b1),
        .RD_DATA(rd_data_b), .RD_VALID(rd_valid_b));

    int checks = 0, passed = 0;
    bit mon_en = 1'b0;
    logic [31:0] mem_m [MD];
    logic [31:0] exp_q [$];
    logic [31:0] exp_w;

    task automatic check(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (mon_en && rd_valid_a) begin
            if (exp_q.size() == 0) check("rd_unexpected", 1'b0, rd_data_a, 32'h0);
            else begin
                exp_w = exp_q.pop_front();
                check("rd_data", rd_data_a === exp_w, rd_data_a, exp_w);
            end
        end
        if (mon_en && rd_valid_b) check("rd_valid_b", 1'b0, 32'h1, 32'h0);
    end

    task automatic run_txn(input logic [3:0] cmd, input logic [31:0] addr, input logic idsel,
                           input int gnt_dly, input bit trig, input bit extra, input bit fixed);
        logic [31:0] wd [ND];
        int k, irdy_cyc, n, base;
        bit started, done, claim;
        claim = idsel && (cmd == CMD_MEM_RD || cmd == CMD_MEM_WR);
        base  = int'(addr[4:2]);
        for (int i = 0; i < ND; i++) wd[i] = fixed ? 32'hA5A5_0001 + i : $urandom;
        for (int i = 0; i < ND; i++) begin
            if (claim && cmd == CMD_MEM_RD) exp_q.push_back(mem_m[(base + i) % MD]);
            if (claim && cmd == CMD_MEM_WR) mem_m[(base + i) % MD] = wd[i];
        end
        ad_to_c = addr; cbe_to_c = cmd; idsel_b = idsel;
        if (trig) begin
            repeat (2) @(negedge clk);
            forced_en_a = 1'b0;
            @(negedge clk);
            forced_en_a = 1'b1;
            for (int i = 0; i < gnt_dly; i++) begin
                check("req_no_gnt", req_a == 1'b0 && frame_in == 1'b1, {req_a, frame_in}, 2'b01);
                @(negedge clk);
            end
        end
        gnt_a = 1'b0;
        started = 0; done = 0; k = 0; irdy_cyc = 0; n = 0;
        while (!done && n < 60) begin
            @(negedge clk); n++;
            if (!started) begin
                if (frame_a == 1'b0 && irdy_a == 1'b1) begin started = 1; gnt_a = 1'b1; end
            end else begin
                if (irdy_a == 1'b0) irdy_cyc++;
                if (extra) forced_en_a = (irdy_cyc != 1);
                ad_to_c = wd[(k < ND) ? k : ND - 1];
                if (!irdy_in && !trdy_in) begin
                    check("frame_last", frame_a == (k == ND - 1), frame_a, (k == ND - 1));
                    k++;
                end
                if (frame_a && irdy_a) done = 1;
            end
        end
        forced_en_a = 1'b1; gnt_a = 1'b1;
        if (!done) check("txn_timeout", 1'b0, n, 60);
        check("xfer_count", k == (claim ? ND : 0), k, claim ? ND : 0);
        check("irdy_cycles", irdy_cyc == (claim ? 1 + ND * (1 + WS) : AC),
              irdy_cyc, claim ? 1 + ND * (1 + WS) : AC);
        if (!claim) check("abort_req", req_a == 1'b1 && frame_in == 1'b1, {req_a, frame_in}, 2'b11);
    endtask

    task automatic check_quiet(input string nm, input int cycles);
        bit ok = 1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (!(req_a && frame_in && irdy_in)) ok = 0;
        end
        check(nm, ok, {req_a, frame_in, irdy_in}, 3'b111);
    endtask

    initial begin
        rst = 1'b1; gnt_a = 1'b1; idsel_b = 1'b0; forced_en_a = 1'b1;
        ad_to_c = '0; cbe_to_c = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_frame",  frame_in  == 1'b1, frame_in, 1);
        check("rst_irdy",   irdy_in   == 1'b1, irdy_in, 1);
        check("rst_trdy",   trdy_in   == 1'b1, trdy_in, 1);
        check("rst_devsel", devsel_in == 1'b1, devsel_in, 1);
        check("rst_req",    req_a     == 1'b1, req_a, 1);
        check("rst_rdv",    rd_valid_a == 1'b0, rd_valid_a, 0);
        check("rst_rdd",    rd_data_a == 32'h0, rd_data_a, 0);
        mon_en = 1'b1;

        // directed: write/read-back at 0 (with 5-clock grant delay), fill, wrap
        run_txn(CMD_MEM_WR, 32'h0000_0000, 1'b1, 5, 1, 0, 1);
        run_txn(CMD_MEM_RD, 32'h0000_0000, 1'b1, 0, 1, 0, 0);
        run_txn(CMD_MEM_WR, 32'h0000_000C, 1'b1, 1, 1, 0, 0);
        run_txn(CMD_MEM_WR, 32'h0000_0018, 1'b1, 0, 1, 0, 0);
        run_txn(CMD_MEM_WR, 32'h0000_001C, 1'b1, 2, 1, 0, 0);
        run_txn(CMD_MEM_RD, 32'h0000_001C, 1'b1, 0, 1, 0, 0);
        run_txn(CMD_MEM_RD, 32'h0000_0008, 1'b1, 0, 1, 0, 0);
        // master abort: nobody selected
        run_txn(CMD_MEM_RD, 32'h0000_0000, 1'b0, 0, 1, 0, 0);
        // second trigger during a burst -> exactly one follow-up transaction
        run_txn(CMD_MEM_WR, 32'h0000_0010, 1'b1, 0, 1, 1, 0);
        run_txn(CMD_MEM_RD, 32'h0000_0010, 1'b1, 0, 0, 0, 0);
        check_quiet("no_extra_txn", 8);

        for (int t = 0; t < 14; t++) begin
            int r;
            logic [3:0] c;
            logic [31:0] a;
            logic sel;
            r   = $urandom_range(0, 9);
            c   = (r < 4) ? CMD_MEM_RD : (r < 8) ? CMD_MEM_WR : 4'b0010;
            sel = ($urandom_range(0, 7) != 0);
            a   = ($urandom & 32'hFFFF_FFE0) | (32'($urandom_range(0, MD - 1)) << 2);
            run_txn(c, a, sel, $urandom_range(0, 3), 1, 0, 0);
        end

        // asynchronous reset in the claim cycle of a write, with a pending trigger
        mon_en = 1'b0;
        ad_to_c = 32'h0; cbe_to_c = CMD_MEM_WR; idsel_b = 1'b1;
        repeat (2) @(negedge clk);
        forced_en_a = 1'b0;
        @(negedge clk);
        forced_en_a = 1'b1; gnt_a = 1'b0;
        begin
            int n = 0;
            while (!(frame_a == 1'b0 && irdy_a == 1'b1) && n < 20) begin @(negedge clk); n++; end
            if (n >= 20) check("rst_txn_start", 1'b0, n, 20);
        end
        forced_en_a = 1'b0; gnt_a = 1'b1;
        @(negedge clk);
        forced_en_a = 1'b1;
        check("claim_before_rst", devsel_in == 1'b0 && irdy_in == 1'b0, {devsel_in, irdy_in}, 2'b00);
        #2 rst = 1'b1;
        #1;
        check("arst_ctl", {frame_in, irdy_in, trdy_in, devsel_in, req_a} == 5'h1F,
              {frame_in, irdy_in, trdy_in, devsel_in, req_a}, 5'h1F);
        check("arst_rdv", rd_valid_a == 1'b0, rd_valid_a, 0);
        @(negedge clk);
        rst = 1'b0;
        check_quiet("pending_dropped", 8);
        mon_en = 1'b1;

        // memory survives reset; the aborted write moved nothing
        run_txn(CMD_MEM_RD, 32'h0000_0004, 1'b1, 0, 1, 0, 0);
        repeat (2) @(negedge clk);
        check("scoreboard_empty", exp_q.size() == 0, exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
